rs_issue_select: RTL
====================

// Module: rs_issue_select
// PURPOSE
//  Issue-select stage downstream of the RS array: each cycle picks, per issue port, the oldest RS entry
//  woken for that port, drives the one-hot issue crossbar select and per-entry use enables back to the RS,
//  and tracks a registered issue-stage valid per port with FU backpressure. Sits between RS array and FUs.
// PARAMETERS
//  RS_DEPTH     16            number of RS entries
//  ISSUE_W      `ISSUE_WIDTH  issue ports (default 3)
//  AGE_W        `ROB_WIDTH+1  age width: ROB index plus wrap bit
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  rst          in   1                   asynchronous reset, active-high
//  pipe_flush   in   1                   squash all in-flight issue state
//  rs_wake_up   in   [ISSUE_W-1:0] x RS_DEPTH  entry i ready for port p
//  rs_age       in   [AGE_W-1:0] x RS_DEPTH    ROB tag (with wrap bit) of entry i
//  rob_head     in   AGE_W               ROB head tag (with wrap bit), oldest in flight
//  fu_ready     in   [ISSUE_W-1:0]       FU p accepts the issue-stage op this cycle
//  issue_sel    out  [RS_DEPTH-1:0] x ISSUE_W  one-hot grant per port (all-zero = none)
//  rs_use_en    out  [RS_DEPTH-1:0]      OR of issue_sel; entry vacates RS this cycle
//  issue_load   out  [ISSUE_W-1:0]       port p granted; downstream packet latch loads
//  issue_valid  out  [ISSUE_W-1:0]       registered: issue-stage op valid toward FU p
// BEHAVIOUR
//  - Relative age: rel_i = rs_age[i] - rob_head, modulo 2^AGE_W; smaller rel = older. Ties impossible
//    (unique ROB tags); if equal, lower index wins.
//  - Port can_grant[p] = !issue_valid[p] | fu_ready[p]. Not can_grant -> issue_sel[p]=0.
//  - Ports resolved in order p=0..ISSUE_W-1: candidates = rs_wake_up[*][p] & ~taken; taken accumulates
//    grants of lower ports, so no entry is granted to two ports in one cycle.
//  - Grant combinational, same cycle as wake-up (0-cycle select); issue_load[p] = |issue_sel[p].
//  - issue_valid[p] next = issue_load[p] ? 1 : (fu_ready[p] ? 0 : issue_valid[p]).
//    FU handshake: op transfers on issue_valid[p] & fu_ready[p]; back-to-back ops allowed (grant and
//    transfer in same cycle keeps issue_valid high).
//  - pipe_flush: issue_sel, rs_use_en, issue_load forced 0 that cycle; issue_valid cleared next edge.
//  - rst asserted: issue_valid=0 immediately (async); combinational outputs forced 0 while rst=1.
//  - No candidate for a port: issue_sel[p]=0, issue_valid follows hold/drain rule above.
//  - rob_head wrap: aging via modular subtraction, correct across wrap-bit toggle.
// CONFIGURATION
//  RS_ISSUE_PERF_EN defined: adds outputs perf_issued[p] (32b) and perf_stall[p] (32b), per port;
//   perf_issued increments on issue_load[p]; perf_stall increments when issue_valid[p] & !fu_ready[p];
//   both saturate at 32'hFFFF_FFFF, reset to 0 by rst, NOT cleared by pipe_flush.
//  Undefined: counters and ports absent; all other behaviour identical.
// TESTING
//  1 Reset: rst=1 mid-run with issue_valid=3'b111 -> issue_valid=0 without clock edge; all sel/use_en=0.
//  2 Age order: head=5; entries 2,7 woken port0, ages 9,6 -> issue_sel[0]=1<<7, rs_use_en=0x0080.
//  3 Wrap: AGE_W=6, head=6'h3E; entry0 age 6'h01, entry1 age 6'h3F, both port0 -> entry1 granted.
//  4 Multi-port exclusion: entry 4 woken ports 0 and 1 only, entry 9 port1 -> sel[0]=bit4, sel[1]=bit9.
//  5 Backpressure: grant port2, fu_ready[2]=0 for 3 cycles with entry 3 woken -> no grant 3 cycles,
//    issue_valid[2]=1 held; fu_ready=1 -> entry 3 granted same cycle, issue_valid stays 1.
//  6 Flush: pipe_flush=1 with 3 woken entries -> rs_use_en=0 that cycle, issue_valid=0 next cycle;
//    with RS_ISSUE_PERF_EN, perf_issued values unchanged by flush.

Source files
------------

// File: rtl/rs_issue_select.sv
// rs_issue_select: per-port oldest-first select from the RS array.
// Each cycle, port p grants the oldest entry woken for p that no lower port has
// already taken. The grant drives the one-hot crossbar select and the RS use
// enables in the same cycle. A registered issue-stage valid per port holds an op
// until the FU accepts it.
// Handshake: an op transfers to FU p on issue_valid[p] & fu_ready[p]. A new grant
// may land in the same cycle as a transfer, which keeps issue_valid[p] high.
// Optional feature macro: RS_ISSUE_PERF_EN adds saturating per-port issued/stall counters.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 3
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

module rs_issue_select #(
  parameter int RS_DEPTH = 16,
  parameter int ISSUE_W  = `ISSUE_WIDTH,
  parameter int AGE_W    = `ROB_WIDTH + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pipe_flush,
  input  logic [RS_DEPTH-1:0][ISSUE_W-1:0]   rs_wake_up,
  input  logic [RS_DEPTH-1:0][AGE_W-1:0]     rs_age,
  input  logic [AGE_W-1:0]                   rob_head,
  input  logic [ISSUE_W-1:0]                 fu_ready,
  output logic [ISSUE_W-1:0][RS_DEPTH-1:0]   issue_sel,
  output logic [RS_DEPTH-1:0]                rs_use_en,
  output logic [ISSUE_W-1:0]                 issue_load,
`ifdef RS_ISSUE_PERF_EN
  output logic [ISSUE_W-1:0][31:0]           perf_issued,
  output logic [ISSUE_W-1:0][31:0]           perf_stall,
`endif
  output logic [ISSUE_W-1:0]                 issue_valid
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0][AGE_W-1:0]   rel_age;
  logic [ISSUE_W-1:0]               can_grant;
  logic [ISSUE_W-1:0][RS_DEPTH-1:0] sel;
  logic [ISSUE_W-1:0]               issue_valid_d, issue_valid_q;

  // Age relative to the ROB head; modular subtraction keeps ordering correct across wrap.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      rel_age[i] = rs_age[i] - rob_head;
    end
  end

  // A port may take a new op when its issue stage is empty or draining this cycle.
  always_comb begin
    can_grant = ~issue_valid_q | fu_ready;
  end

  // Ordered per-port oldest-first pick; lower ports claim entries first.
  always_comb begin : select_blk
    logic [RS_DEPTH-1:0] taken;
    logic                found;
    logic [AGE_W-1:0]    best_rel;
    logic [IDX_W-1:0]    best_idx;
    taken    = '0;
    sel      = '0;
    found    = 1'b0;
    best_rel = '0;
    best_idx = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      found    = 1'b0;
      best_rel = '0;
      best_idx = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        // Strict less-than: on an (impossible) age tie the lower index is kept.
        if (rs_wake_up[i][p] && !taken[i] && (!found || (rel_age[i] < best_rel))) begin
          found    = 1'b1;
          best_rel = rel_age[i];
          best_idx = IDX_W'(i);
        end
      end
      if (found && can_grant[p] && !pipe_flush && !rst) begin
        sel[p][best_idx] = 1'b1;
        taken[best_idx]  = 1'b1;
      end
    end
  end

  // Drive the crossbar select, RS vacate enables and per-port load strobes.
  always_comb begin
    issue_sel = sel;
    rs_use_en = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      rs_use_en     = rs_use_en | sel[p];
      issue_load[p] = |sel[p];
    end
  end

  // Next issue-stage valid: load wins, otherwise drain on FU accept; flush clears.
  always_comb begin
    issue_valid_d = issue_valid_q;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (pipe_flush)         issue_valid_d[p] = 1'b0;
      else if (issue_load[p]) issue_valid_d[p] = 1'b1;
      else if (fu_ready[p])   issue_valid_d[p] = 1'b0;
    end
  end

  // Issue-stage valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) issue_valid_q <= '0;
    else     issue_valid_q <= issue_valid_d;
  end

  assign issue_valid = issue_valid_q;

`ifdef RS_ISSUE_PERF_EN
  logic [ISSUE_W-1:0][31:0] perf_issued_d, perf_issued_q;
  logic [ISSUE_W-1:0][31:0] perf_stall_d, perf_stall_q;

  // Saturating counters; deliberately untouched by pipe_flush.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (issue_load[p] && (perf_issued_q[p] != 32'hFFFF_FFFF))
        perf_issued_d[p] = perf_issued_q[p] + 32'd1;
      if (issue_valid_q[p] && !fu_ready[p] && (perf_stall_q[p] != 32'hFFFF_FFFF))
        perf_stall_d[p] = perf_stall_q[p] + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
